// File: rtl/mercury_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mercury_pkg
//  Description : Shared constants and types for the Mercury seven-segment
//                scanner: blank pattern, hex glyph table, digit image type.
//  Revision    : 1.0 - initial release
// ============================================================================
package mercury_pkg;

    // All segments dark (active-low A..G, A in bit 6)
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Hex glyphs, active-low, bit order A B C D E F G (A = MSB); index = nibble
    localparam logic [15:0][6:0] C_HEX_GLYPHS = {
        7'b0111000,   // F
        7'b0110000,   // E
        7'b1000010,   // d
        7'b0110001,   // C
        7'b1100000,   // b
        7'b0001000,   // A
        7'b0000100,   // 9
        7'b0000000,   // 8
        7'b0001111,   // 7
        7'b0100000,   // 6
        7'b0100100,   // 5
        7'b1001100,   // 4
        7'b0000110,   // 3
        7'b0010010,   // 2
        7'b1001111,   // 1
        7'b0000001    // 0
    };

    // One digit of a display image: segments (or hex nibble in [3:0]) plus dot
    typedef struct packed {
        logic [6:0] seg;
        logic       dot;
    } digit_img_t;

    localparam digit_img_t C_DIGIT_BLANK = '{seg: SEG_OFF, dot: 1'b1};

endpackage
`default_nettype wire

// File: rtl/mercury_hex7.sv
`default_nettype none
// ============================================================================
//  Module      : mercury_hex7
//  Description : Combinational 4-bit to 7-segment (active-low) hex decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module mercury_hex7
    import mercury_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Table lookup of the glyph for the nibble
    always_comb begin
        o_seg = C_HEX_GLYPHS[i_nibble];
    end

endmodule
`default_nettype wire

// File: rtl/mercury_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : mercury_seg_scan
//  Description : Multiplexed common-anode seven-segment scanner with a
//                double-buffered display image loaded by valid/ready.
//                Per-image raw or hex-decoded digits. Optional PWM
//                brightness when SEG_SCAN_PWM_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module mercury_seg_scan
    import mercury_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    app_clk,
    input  logic                    app_rst,
    input  logic                    enable,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic                    upd_hex_mode,
    input  logic [7*NUM_DIGITS-1:0] upd_data,
    input  logic [NUM_DIGITS-1:0]   upd_dots,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [6:0]              a_to_g_out,
    output logic                    dot_out,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Scan state
    logic [PRE_W-1:0] r_presc_q, w_presc_d;
    logic [IDX_W-1:0] r_idx_q,   w_idx_d;

    // Active and pending display images
    digit_img_t [NUM_DIGITS-1:0] r_act_q,  w_act_d;
    digit_img_t [NUM_DIGITS-1:0] r_pend_q, w_pend_d;
    logic                        r_act_hex_q,  w_act_hex_d;
    logic                        r_pend_hex_q, w_pend_hex_d;
    // High while the pending buffer is empty
    logic                        r_upd_ready_q, w_upd_ready_d;

    // Registered outputs
    logic [NUM_DIGITS-1:0] r_an_q,    w_an_d;
    logic [6:0]            r_seg_q,   w_seg_d;
    logic                  r_dot_q,   w_dot_d;
    logic                  r_frame_q, w_frame_d;

    logic       w_presc_wrap;
    logic       w_idx_last;
    logic       w_frame;
    logic       w_accept;
    logic       w_pwm_on;
    digit_img_t w_cur;
    logic [6:0] w_hex_seg;
    logic [6:0] w_seg_sel;
    logic [NUM_DIGITS-1:0] w_an_sel;

`ifdef SEG_SCAN_PWM_EN
    logic [3:0] r_pwm_cnt_q, w_pwm_cnt_d;

    // Free-running duty counter; anode enabled while count <= brightness
    always_comb begin
        w_pwm_cnt_d = r_pwm_cnt_q + 4'd1;
        w_pwm_on    = (r_pwm_cnt_q <= brightness);
    end

    // Duty counter register
    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            r_pwm_cnt_q <= 4'd0;
        end else begin
            r_pwm_cnt_q <= w_pwm_cnt_d;
        end
    end
`else
    // Brightness has no effect without PWM; anode is on the full slot
    logic w_unused_brightness;
    assign w_unused_brightness = ^brightness;
    assign w_pwm_on            = 1'b1;
`endif

    // Prescaler and digit index advance; index wrap marks the frame boundary
    always_comb begin
        w_presc_wrap = (r_presc_q == C_PRE_LAST);
        w_idx_last   = (r_idx_q == C_IDX_LAST);
        w_frame      = w_presc_wrap && w_idx_last;
        w_presc_d    = w_presc_wrap ? '0 : r_presc_q + 1'b1;
        w_idx_d      = r_idx_q;
        if (w_presc_wrap) begin
            w_idx_d = w_idx_last ? '0 : r_idx_q + 1'b1;
        end
        w_frame_d    = w_frame;
    end

    // Double buffer: accept into pending, promote to active at frame boundary.
    // An accept coinciding with a boundary lands in pending and waits a frame.
    always_comb begin
        w_act_d       = r_act_q;
        w_act_hex_d   = r_act_hex_q;
        w_pend_d      = r_pend_q;
        w_pend_hex_d  = r_pend_hex_q;
        w_upd_ready_d = r_upd_ready_q;
        w_accept      = upd_valid && r_upd_ready_q;

        if (w_frame && !r_upd_ready_q) begin
            w_act_d       = r_pend_q;
            w_act_hex_d   = r_pend_hex_q;
            w_upd_ready_d = 1'b1;
        end

        if (w_accept) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                w_pend_d[d].seg = upd_data[7*d +: 7];
                w_pend_d[d].dot = upd_dots[d];
            end
            w_pend_hex_d  = upd_hex_mode;
            w_upd_ready_d = 1'b0;
        end
    end

    assign w_cur = r_act_q[r_idx_q];

    mercury_hex7 u_hex7 (
        .i_nibble (w_cur.seg[3:0]),
        .o_seg    (w_hex_seg)
    );

    // Output pattern for the selected digit, blanked when disabled
    always_comb begin
        w_seg_sel = r_act_hex_q ? w_hex_seg : w_cur.seg;
        w_an_sel  = ~(NUM_DIGITS'(1) << r_idx_q);
        w_an_d    = '1;
        w_seg_d   = SEG_OFF;
        w_dot_d   = 1'b1;
        if (enable) begin
            w_an_d  = w_pwm_on ? w_an_sel : '1;
            w_seg_d = w_seg_sel;
            w_dot_d = w_cur.dot;
        end
    end

    // State and output registers
    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            r_presc_q     <= '0;
            r_idx_q       <= '0;
            r_act_q       <= {NUM_DIGITS{C_DIGIT_BLANK}};
            r_pend_q      <= {NUM_DIGITS{C_DIGIT_BLANK}};
            r_act_hex_q   <= 1'b0;
            r_pend_hex_q  <= 1'b0;
            r_upd_ready_q <= 1'b1;
            r_an_q        <= '1;
            r_seg_q       <= SEG_OFF;
            r_dot_q       <= 1'b1;
            r_frame_q     <= 1'b0;
        end else begin
            r_presc_q     <= w_presc_d;
            r_idx_q       <= w_idx_d;
            r_act_q       <= w_act_d;
            r_pend_q      <= w_pend_d;
            r_act_hex_q   <= w_act_hex_d;
            r_pend_hex_q  <= w_pend_hex_d;
            r_upd_ready_q <= w_upd_ready_d;
            r_an_q        <= w_an_d;
            r_seg_q       <= w_seg_d;
            r_dot_q       <= w_dot_d;
            r_frame_q     <= w_frame_d;
        end
    end

    assign upd_ready  = r_upd_ready_q;
    assign an_out     = r_an_q;
    assign a_to_g_out = r_seg_q;
    assign dot_out    = r_dot_q;
    assign frame_done = r_frame_q;

endmodule
`default_nettype wire

// File: tb/tb_mercury_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mercury_seg_scan
//  Description : Directed self-checking bench for mercury_seg_scan
//                (NUM_DIGITS = 4, REFRESH_DIV = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mercury_seg_scan;

    localparam int ND = 4;
    localparam int RD = 4;

    logic          app_clk      = 1'b0;
    logic          app_rst      = 1'b1;
    logic          enable       = 1'b1;
    logic          upd_valid    = 1'b0;
    logic          upd_hex_mode = 1'b0;
    logic [7*ND-1:0] upd_data   = '0;
    logic [ND-1:0] upd_dots     = '1;
    logic [3:0]    brightness   = 4'd3;
    logic          upd_ready;
    logic [ND-1:0] an_out;
    logic [6:0]    a_to_g_out;
    logic          dot_out;
    logic          frame_done;

    mercury_seg_scan #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .app_clk      (app_clk),
        .app_rst      (app_rst),
        .enable       (enable),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_hex_mode (upd_hex_mode),
        .upd_data     (upd_data),
        .upd_dots     (upd_dots),
        .brightness   (brightness),
        .an_out       (an_out),
        .a_to_g_out   (a_to_g_out),
        .dot_out      (dot_out),
        .frame_done   (frame_done)
    );

    always #5 app_clk = ~app_clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int k      = -1;           // edges since reset release, minus one

    // Expected image currently on display, and expected enable at the outputs
    logic [6:0] cur_seg [ND];
    logic [3:0] cur_dot;
    logic       exp_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic set_img(input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic [3:0] d);
        cur_seg[0] = s0;
        cur_seg[1] = s1;
        cur_seg[2] = s2;
        cur_seg[3] = s3;
        cur_dot    = d;
    endtask

    // One clock, then compare all scan outputs against the expected image
    task automatic step();
        int         dg;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dot;
        @(posedge app_clk);
        #1;
        k++;
        dg    = (k / RD) % ND;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dot = 1'b1;
        if (exp_en) begin
            e_an[dg] = 1'b0;
            e_seg    = cur_seg[dg];
            e_dot    = cur_dot[dg];
`ifdef SEG_SCAN_PWM_EN
            if ((k % 16) > int'(brightness)) e_an = 4'hF;
`endif
        end
        check("an_out",     {28'd0, an_out},     {28'd0, e_an});
        check("a_to_g_out", {25'd0, a_to_g_out}, {25'd0, e_seg});
        check("dot_out",    {31'd0, dot_out},    {31'd0, e_dot});
        check("frame_done", {31'd0, frame_done}, {31'd0, ((k % 16) == 15)});
    endtask

    task automatic run_to(input int t);
        while (k < t) step();
    endtask

    initial begin
        set_img(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'hF);
        exp_en = 1'b1;

        // Reset values
        repeat (3) @(posedge app_clk);
        #1;
        check("rst_an",    {28'd0, an_out},     32'hF);
        check("rst_seg",   {25'd0, a_to_g_out}, 32'h7F);
        check("rst_dot",   {31'd0, dot_out},    32'h1);
        check("rst_frame", {31'd0, frame_done}, 32'h0);
        check("rst_ready", {31'd0, upd_ready},  32'h1);
        app_rst = 1'b0;
        k = -1;

        // Blank scan, first frame and into the second
        run_to(20);

        // Image A: hex 4321, dots 1010 (upper bits of digit 2 field are junk)
        upd_valid    = 1'b1;
        upd_hex_mode = 1'b1;
        upd_data     = {7'h04, 7'h73, 7'h02, 7'h01};
        upd_dots     = 4'b1010;
        step();                                         // k=21, accepted
        check("ready_after_A", {31'd0, upd_ready}, 32'h0);

        // Image B offered while pending is full; must not be taken
        upd_hex_mode = 1'b0;
        upd_data     = {7'h78, 7'h56, 7'h34, 7'h12};
        upd_dots     = 4'b0101;
        run_to(30);
        check("ready_blocked", {31'd0, upd_ready}, 32'h0);
        step();                                         // k=31 boundary
        check("ready_after_copy", {31'd0, upd_ready}, 32'h1);

        set_img(7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 4'b1010);
        step();                                         // k=32, B accepted
        check("ready_after_B", {31'd0, upd_ready}, 32'h0);
        upd_valid = 1'b0;
        run_to(47);
        check("ready_k47", {31'd0, upd_ready}, 32'h1);

        // Image C accepted in the frame_done cycle: hex A b C d, dots 0011
        upd_valid    = 1'b1;
        upd_hex_mode = 1'b1;
        upd_data     = {7'h0D, 7'h2C, 7'h5B, 7'h0A};
        upd_dots     = 4'b0011;
        set_img(7'h12, 7'h34, 7'h56, 7'h78, 4'b0101);
        step();                                         // k=48
        check("ready_after_C", {31'd0, upd_ready}, 32'h0);
        upd_valid = 1'b0;
        run_to(63);
        set_img(7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 4'b0011);
        run_to(78);

        // Image D accepted on the boundary edge itself: no bypass
        upd_valid    = 1'b1;
        upd_hex_mode = 1'b0;
        upd_data     = {7'h70, 7'h0F, 7'h55, 7'h2A};
        upd_dots     = 4'b1001;
        step();                                         // k=79
        check("ready_after_D", {31'd0, upd_ready}, 32'h0);
        upd_valid = 1'b0;
        run_to(95);
        check("ready_k95", {31'd0, upd_ready}, 32'h1);
        set_img(7'h2A, 7'h55, 7'h0F, 7'h70, 4'b1001);
        run_to(108);

        // Display disabled across a frame boundary
        enable = 1'b0;
        exp_en = 1'b0;
        step();                                         // k=109 dark
        run_to(112);
        upd_valid    = 1'b1;
        upd_hex_mode = 1'b1;
        upd_data     = '0;
        upd_dots     = 4'b0000;
        step();                                         // k=113, E accepted
        upd_valid = 1'b0;
        check("ready_after_E", {31'd0, upd_ready}, 32'h0);
        enable = 1'b1;
        exp_en = 1'b1;
        run_to(118);

        // Mid-frame reset discards both images
        app_rst = 1'b1;
        @(posedge app_clk);
        #1;
        check("mrst_an",    {28'd0, an_out},     32'hF);
        check("mrst_seg",   {25'd0, a_to_g_out}, 32'h7F);
        check("mrst_ready", {31'd0, upd_ready},  32'h1);
        app_rst = 1'b0;
        k = -1;
        set_img(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'hF);
        run_to(35);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mercury_seg_scan.md
# mercury_seg_scan

Parametrised multiplexed seven-segment scanner; successor to the fixed four-digit driver on the Mercury baseboard. It drives NUM_DIGITS common-anode digits from a double-buffered display image loaded through a valid/ready handshake. Each digit is either raw-segment or hex-decoded, and an optional PWM brightness control is available. Sits between application logic and the board's AN/A_TO_G/DOT pins in the app_clk50 domain.

## Interface
- NUM_DIGITS, 4, digit count, legal 1..8
- REFRESH_DIV, 50000, app_clk cycles per digit slot, legal ≥ 2
- app_clk  in  1  scan clock
- app_rst  in  1  reset; one clock; synchronous and active-high
- enable  in  1  1 = drive display; 0 = all digits dark
- upd_valid  in  1  new display image offered
- upd_ready  out  1  pending buffer empty; image accepted when valid & ready
- upd_hex_mode  in  1  1 = low nibble of each digit field is hex-decoded; 0 = raw segments
- upd_data  in  7*NUM_DIGITS  digit d in bits [7d+6:7d], raw A..G active-low or hex nibble in [7d+3:7d]
- upd_dots  in  NUM_DIGITS  decimal points, active-low
- brightness  in  4  duty select, used only with the PWM feature
- an_out  out  NUM_DIGITS  anodes, active-low; an_out[0] = rightmost digit
- a_to_g_out  out  7  segments A..G, active-low
- dot_out  out  1  decimal point, active-low
- frame_done  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0

## Operation
- Prescaler counts 0..REFRESH_DIV-1 and wraps. At terminal count the digit index advances 0..NUM_DIGITS-1 and wraps.
- Index wrap is the frame boundary: frame_done pulses, and the pending buffer is copied to the active buffer if it was full at the start of that cycle. The pending buffer then empties.
- Handshake: valid & ready stores upd_data, upd_dots and upd_hex_mode into the pending buffer and drops upd_ready.
  - upd_ready returns high the cycle after the frame-boundary copy.
  - upd_data must stay stable only in the accept cycle.
- An accept and a frame boundary in the same cycle with pending empty: the new image waits for the next boundary. There is no bypass.
- A pending buffer that is already full blocks new offers. No overwrite.
- Hex decode covers 0..F with standard glyphs (0 = 7'b0000001, 1 = 7'b1001111, ..., F = 7'b0111000). Bits [7d+6:7d+4] are ignored in hex mode.
- enable = 0 forces an_out all ones, a_to_g_out = 7'h7F and dot_out = 1. The prescaler, index, handshake and frame_done keep running.
- All outputs are registered.

## Timing
- Reset values: an_out all ones, a_to_g_out 7'h7F, dot_out 1, frame_done 0, upd_ready 1. Prescaler 0, index 0, both buffers 7'h7F/dots 1 (blank, raw mode).
- Reset mid-frame discards the pending and active images; scanning restarts at digit 0.
- Output latency: outputs reflect an index change 1 cycle after the index register updates.
- Digit slot is REFRESH_DIV cycles; a frame is NUM_DIGITS*REFRESH_DIV cycles.
- An image accepted at cycle t appears on the outputs 1 cycle after the first frame boundary strictly after t.
- frame_done is asserted in the same cycle the active buffer takes the new image.

## Configuration
- SEG_SCAN_PWM_EN defined:
  - A free-running 4-bit pwm counter increments every cycle.
  - The selected anode is driven low only while pwm_cnt ≤ brightness. brightness 0 gives 1/16 duty; 15 gives full on.
  - Segments stay valid the whole slot.
- SEG_SCAN_PWM_EN undefined: brightness is ignored, the anode is on for the full slot, and no pwm counter exists.

## Structure
- Shared package mercury_pkg holds:
  - SEG_OFF (7'h7F)
  - the 16-entry hex-to-segment glyph constants
  - the digit-image typedef (7-bit segments + dot)
- One sub-module, mercury_hex7: combinational 4-bit to 7-segment active-low decoder, instantiated once on the selected digit.

## Test plan
Bench uses NUM_DIGITS = 4, REFRESH_DIV = 4.
- Reset release, enable = 1, no update -> an_out cycles 1110, 1101, 1011, 0111 every 4 cycles; a_to_g_out = 7'h7F; frame_done pulses every 16 cycles.
- Hex update 16'h4321 in 4 × 7-bit fields, hex_mode = 1, dots 4'b1010 -> after the next boundary:
  - digit 0 shows 7'b1001111 with dot 0, digit 1 shows 7'b0010010 with dot 1
  - digit 2 shows 7'b0000110, digit 3 shows 7'b1001100
- Second upd_valid while pending is full -> upd_ready = 0 and the offer is not taken. After the boundary the first image is displayed, upd_ready = 1, and the second image is accepted.
- Accept in the exact frame_done cycle -> image not shown that frame; shown after the following boundary, 16 cycles later.
- enable = 0 mid-frame -> an_out = 4'b1111 next cycle; frame_done cadence unchanged.
- SEG_SCAN_PWM_EN with brightness = 3 -> the selected anode is low 4 of every 16 cycles. With brightness = 15 it is always low within its slot. Without the macro it is always low.
